hms_batch_selector: RTL and testbench

Parametrised two-way batch selector that sits directly in front of MERGE_NETWORK in the hardware merge sorter. Two input channels each deliver sorted batches of 2^E_LOG records into internal FIFOs; each cycle the block forwards the batch whose head key is smaller. It generalises the fixed FIFO/comparator/mux front end with:

- configurable FIFO depth;
- output back-pressure;
- end-of-stream handling: drain the surviving channel, then flag completion.

---
 rtl/hms_batch_selector_pkg.sv | 17 +
 rtl/hms_batch_selector_if.sv | 35 +++
 rtl/hms_batch_selector_fifo.sv | 59 +++++
 rtl/hms_batch_selector.sv | 123 ++++++++++++
 tb/tb_hms_batch_selector.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/hms_batch_selector_pkg.sv
// Shared defaults and state encoding for the merge-sorter batch selector.
package hms_batch_selector_pkg;

  localparam int unsigned E_LOG_DEF    = 2;
  localparam int unsigned DATW_DEF     = 64;
  localparam int unsigned KEYW_DEF     = 32;
  localparam int unsigned FIFO_LOG_DEF = 2;
  localparam int unsigned CNTW         = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN_A = 2'd2,
    DRAIN_B = 2'd3
  } sel_state_e;

endpackage

// File: rtl/hms_batch_selector_if.sv
// Two batch input channels plus the back-pressured output slot of the selector.
interface hms_batch_selector_if
  import hms_batch_selector_pkg::*;
#(
  parameter int unsigned DATW  = DATW_DEF,
  parameter int unsigned E_LOG = E_LOG_DEF
);
  localparam int unsigned BW = DATW << E_LOG;

  logic            a_enq;
  logic [BW-1:0]   a_din;
  logic            a_last;
  logic            a_ful;
  logic            b_enq;
  logic [BW-1:0]   b_din;
  logic            b_last;
  logic            b_ful;
  logic [BW-1:0]   out_dot;
  logic            out_doten;
  logic            out_last;
  logic            out_rdy;
  logic [CNTW-1:0] out_cnt;
  logic            busy;

  modport master (
    output a_enq, a_din, a_last, b_enq, b_din, b_last, out_rdy,
    input  a_ful, b_ful, out_dot, out_doten, out_last, out_cnt, busy
  );

  modport slave (
    input  a_enq, a_din, a_last, b_enq, b_din, b_last, out_rdy,
    output a_ful, b_ful, out_dot, out_doten, out_last, out_cnt, busy
  );

endinterface

// File: rtl/hms_batch_selector_fifo.sv
// Per-channel entry FIFO; enqueue while full is dropped, emp/ful are registered.
module hms_sel_fifo #(
  parameter int unsigned W   = 8,
  parameter int unsigned LOG = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         enq,
  input  logic [W-1:0] din,
  input  logic         deq,
  output logic [W-1:0] dout,
  output logic         emp,
  output logic         ful
);
  localparam int unsigned DEPTH = 1 << LOG;
  localparam int unsigned CW    = LOG + 1;

  logic [W-1:0]   mem_q [DEPTH];
  logic [LOG-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           emp_q, emp_d, ful_q, ful_d;
  logic           push_c, pop_c;

  always_comb begin
    push_c = enq && !ful_q;
    pop_c  = deq && !emp_q;
    wr_d   = wr_q + LOG'(push_c);
    rd_d   = rd_q + LOG'(pop_c);
    cnt_d  = cnt_q + CW'(push_c) - CW'(pop_c);
    emp_d  = (cnt_d == '0);
    ful_d  = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      emp_q <= 1'b1;
      ful_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      emp_q <= emp_d;
      ful_q <= ful_d;
    end
  end

  // Storage carries no reset; emp_q guards every read of stale entries.
  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wr_q] <= din;
  end

  assign dout = mem_q[rd_q];
  assign emp  = emp_q;
  assign ful  = ful_q;

endmodule

// File: rtl/hms_batch_selector.sv
// Two-way batch selector: forwards the FIFO head with the smaller lane-0 key,
// then drains the surviving channel once the other stream has ended.
module hms_batch_selector
  import hms_batch_selector_pkg::*;
#(
  parameter int unsigned E_LOG    = E_LOG_DEF,
  parameter int unsigned DATW     = DATW_DEF,
  parameter int unsigned KEYW     = KEYW_DEF,
  parameter int unsigned FIFO_LOG = FIFO_LOG_DEF
) (
  input logic                  CLK,
  input logic                  RST,
  hms_batch_selector_if.slave  bus
);
  localparam int unsigned BW = DATW << E_LOG;
  localparam int unsigned EW = BW + 1;

  logic [EW-1:0]   a_head, b_head;
  logic            a_emp, b_emp, a_ful, b_ful;
  logic            deq_a_c, deq_b_c, slot_free_c;
  logic [KEYW-1:0] ka, kb;

  sel_state_e      state_q, state_d;
  logic [BW-1:0]   out_dot_q, out_dot_d;
  logic            out_doten_q, out_doten_d;
  logic            out_last_q, out_last_d;
  logic [CNTW-1:0] out_cnt_q, out_cnt_d;
  logic            busy_q, busy_d;

  hms_sel_fifo #(.W(EW), .LOG(FIFO_LOG)) u_fifo_a (
    .CLK (CLK), .RST (RST),
    .enq (bus.a_enq), .din ({bus.a_last, bus.a_din}),
    .deq (deq_a_c), .dout (a_head), .emp (a_emp), .ful (a_ful)
  );

  hms_sel_fifo #(.W(EW), .LOG(FIFO_LOG)) u_fifo_b (
    .CLK (CLK), .RST (RST),
    .enq (bus.b_enq), .din ({bus.b_last, bus.b_din}),
    .deq (deq_b_c), .dout (b_head), .emp (b_emp), .ful (b_ful)
  );

  assign ka          = a_head[KEYW-1:0];
  assign kb          = b_head[KEYW-1:0];
  assign slot_free_c = !out_doten_q || bus.out_rdy;

  always_comb begin
    state_d     = state_q;
    out_dot_d   = out_dot_q;
    out_doten_d = out_doten_q;
    out_last_d  = out_last_q;
    out_cnt_d   = out_cnt_q + CNTW'(out_doten_q && bus.out_rdy);
    deq_a_c     = 1'b0;
    deq_b_c     = 1'b0;
    if (slot_free_c) begin
      out_doten_d = 1'b0;
      out_last_d  = 1'b0;
    end
    case (state_q)
      IDLE: if (bus.a_enq || bus.b_enq) state_d = RUN;
      // Ties go to A; a channel's last batch hands over to draining the other.
      RUN: if (!a_emp && !b_emp && slot_free_c) begin
        if (ka <= kb) begin
          deq_a_c = 1'b1;
          if (a_head[BW]) state_d = DRAIN_B;
        end else begin
          deq_b_c = 1'b1;
          if (b_head[BW]) state_d = DRAIN_A;
        end
      end
      DRAIN_A: if (!a_emp && slot_free_c) begin
        deq_a_c = 1'b1;
        if (a_head[BW]) begin
          out_last_d = 1'b1;
          state_d    = IDLE;
        end
      end
      DRAIN_B: if (!b_emp && slot_free_c) begin
        deq_b_c = 1'b1;
        if (b_head[BW]) begin
          out_last_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (deq_a_c) begin
      out_dot_d   = a_head[BW-1:0];
      out_doten_d = 1'b1;
    end
    if (deq_b_c) begin
      out_dot_d   = b_head[BW-1:0];
      out_doten_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      out_dot_q   <= '0;
      out_doten_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_dot_q   <= out_dot_d;
      out_doten_q <= out_doten_d;
      out_last_q  <= out_last_d;
      out_cnt_q   <= out_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.a_ful     = a_ful;
  assign bus.b_ful     = b_ful;
  assign bus.out_dot   = out_dot_q;
  assign bus.out_doten = out_doten_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_hms_batch_selector.sv
// Directed bench for hms_batch_selector: merge order, ties, drain, stall, full, reset.
module tb_hms_batch_selector;
  localparam int unsigned EL = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned NL = 1 << EL;
  localparam int unsigned BW = DW << EL;

  typedef logic [34:0] rec_t; // {from_a, last, lanes_ok, key}

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  hms_batch_selector_if #(.DATW(DW), .E_LOG(EL)) bus ();

  hms_batch_selector #(.E_LOG(EL), .DATW(DW), .KEYW(32), .FIFO_LOG(2)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  rec_t got_q[$];
  rec_t exp_q[$];

  // Lane i: {channel tag, lane index, key+i}; lane 0 holds the smallest key.
  function automatic logic [BW-1:0] mk(input logic from_a, input logic [31:0] k);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++)
      r[i*DW +: DW] = {from_a ? 16'hAAAA : 16'hBBBB, 16'(i), k + 32'(i)};
    return r;
  endfunction

  function automatic rec_t ent(input logic from_a, input logic last, input logic [31:0] k);
    return {from_a, last, 1'b1, k};
  endfunction

  // Record every batch the downstream side accepts.
  always @(negedge CLK) begin
    if (!RST && bus.out_doten && bus.out_rdy)
      got_q.push_back({bus.out_dot[DW-1 -: 16] == 16'hAAAA, bus.out_last,
                       bus.out_dot == mk(bus.out_dot[DW-1 -: 16] == 16'hAAAA, bus.out_dot[31:0]),
                       bus.out_dot[31:0]});
  end

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ae, input logic [31:0] ak, input logic al,
                       input logic be, input logic [31:0] bk, input logic bl);
    bus.a_enq  = ae;
    bus.a_din  = ae ? mk(1'b1, ak) : '0;
    bus.a_last = al;
    bus.b_enq  = be;
    bus.b_din  = be ? mk(1'b0, bk) : '0;
    bus.b_last = bl;
    tick();
    bus.a_enq  = 1'b0;
    bus.a_last = 1'b0;
    bus.b_enq  = 1'b0;
    bus.b_last = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 80 && got_q.size() < n; i++) tick();
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, " count"}, BW'(got_q.size()), BW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk($sformatf("%s[%0d]", tag, i), BW'(got_q[i]), BW'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " a_ful"},     BW'(bus.a_ful),     '0);
    chk({tag, " b_ful"},     BW'(bus.b_ful),     '0);
    chk({tag, " out_doten"}, BW'(bus.out_doten), '0);
    chk({tag, " out_last"},  BW'(bus.out_last),  '0);
    chk({tag, " out_dot"},   bus.out_dot,        '0);
    chk({tag, " out_cnt"},   BW'(bus.out_cnt),   '0);
    chk({tag, " busy"},      BW'(bus.busy),      '0);
  endtask

  initial begin
    bus.a_enq = 1'b0; bus.a_din = '0; bus.a_last = 1'b0;
    bus.b_enq = 1'b0; bus.b_din = '0; bus.b_last = 1'b0;
    bus.out_rdy = 1'b0;
    RST = 1'b1;
    tick();
    tick();
    chk_reset("reset");
    RST = 1'b0;

    // Interleaved streams, downstream always ready.
    bus.out_rdy = 1'b1;
    drive(1'b1, 32'd1, 1'b0, 1'b1, 32'd5, 1'b0);
    chk("s1 busy_rise", BW'(bus.busy), BW'(1'b1));
    drive(1'b1, 32'd9, 1'b0, 1'b1, 32'd13, 1'b0);
    drive(1'b1, 32'd17, 1'b1, 1'b1, 32'd21, 1'b1);
    wait_out(6);
    tick();
    chk("s1 out_cnt", BW'(bus.out_cnt), BW'(32'd6));
    chk("s1 busy_fall", BW'(bus.busy), BW'(1'b0));
    exp_q = '{ent(1'b1, 1'b0, 32'd1), ent(1'b0, 1'b0, 32'd5), ent(1'b1, 1'b0, 32'd9),
              ent(1'b0, 1'b0, 32'd13), ent(1'b1, 1'b0, 32'd17), ent(1'b0, 1'b1, 32'd21)};
    chk_stream("s1 order");

    // Equal head keys: A wins.
    drive(1'b1, 32'd7, 1'b1, 1'b1, 32'd7, 1'b1);
    wait_out(2);
    tick();
    chk("s2 out_cnt", BW'(bus.out_cnt), BW'(32'd8));
    exp_q = '{ent(1'b1, 1'b0, 32'd7), ent(1'b0, 1'b1, 32'd7)};
    chk_stream("s2 tie");

    // A ends after one batch; B drains alone.
    drive(1'b1, 32'd3, 1'b1, 1'b1, 32'd4, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'd12, 1'b1);
    wait_out(4);
    tick();
    chk("s3 out_cnt", BW'(bus.out_cnt), BW'(32'd12));
    exp_q = '{ent(1'b1, 1'b0, 32'd3), ent(1'b0, 1'b0, 32'd4),
              ent(1'b0, 1'b0, 32'd8), ent(1'b0, 1'b1, 32'd12)};
    chk_stream("s3 drain");

    // Back-pressure: ten stalled cycles; B99, A98 and B97 must be dropped.
    bus.out_rdy = 1'b0;
    drive(1'b1, 32'd20, 1'b0, 1'b1, 32'd21, 1'b0);
    drive(1'b1, 32'd22, 1'b0, 1'b1, 32'd23, 1'b0);
    drive(1'b1, 32'd24, 1'b0, 1'b1, 32'd25, 1'b0);
    drive(1'b1, 32'd26, 1'b0, 1'b1, 32'd27, 1'b0);
    drive(1'b1, 32'd28, 1'b1, 1'b1, 32'd99, 1'b0);
    drive(1'b1, 32'd98, 1'b0, 1'b1, 32'd97, 1'b0);
    chk("s4 a_ful", BW'(bus.a_ful), BW'(1'b1));
    chk("s4 b_ful", BW'(bus.b_ful), BW'(1'b1));
    chk("s4 doten_held", BW'(bus.out_doten), BW'(1'b1));
    chk("s4 dot_early", bus.out_dot, mk(1'b1, 32'd20));
    for (int i = 0; i < 4; i++) tick();
    chk("s4 dot_late", bus.out_dot, mk(1'b1, 32'd20));
    chk("s4 cnt_held", BW'(bus.out_cnt), BW'(32'd12));
    bus.out_rdy = 1'b1;
    tick();
    tick();
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'd29, 1'b1);
    wait_out(10);
    tick();
    chk("s4 out_cnt", BW'(bus.out_cnt), BW'(32'd22));
    exp_q = '{ent(1'b1, 1'b0, 32'd20), ent(1'b0, 1'b0, 32'd21), ent(1'b1, 1'b0, 32'd22),
              ent(1'b0, 1'b0, 32'd23), ent(1'b1, 1'b0, 32'd24), ent(1'b0, 1'b0, 32'd25),
              ent(1'b1, 1'b0, 32'd26), ent(1'b0, 1'b0, 32'd27), ent(1'b1, 1'b0, 32'd28),
              ent(1'b0, 1'b1, 32'd29)};
    chk_stream("s4 stall");

    // Full A with a same-cycle dequeue: A50 is dropped, A leaves full.
    bus.out_rdy = 1'b0;
    drive(1'b1, 32'd40, 1'b0, 1'b1, 32'd60, 1'b1);
    drive(1'b1, 32'd42, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 32'd44, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 32'd46, 1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 32'd48, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("s5 a_ful_set", BW'(bus.a_ful), BW'(1'b1));
    bus.out_rdy = 1'b1;
    drive(1'b1, 32'd50, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("s5 a_ful_clr", BW'(bus.a_ful), BW'(1'b0));
    wait_out(6);
    tick();
    chk("s5 out_cnt", BW'(bus.out_cnt), BW'(32'd28));
    exp_q = '{ent(1'b1, 1'b0, 32'd40), ent(1'b1, 1'b0, 32'd42), ent(1'b1, 1'b0, 32'd44),
              ent(1'b1, 1'b0, 32'd46), ent(1'b1, 1'b0, 32'd48), ent(1'b0, 1'b1, 32'd60)};
    chk_stream("s5 full");

    // Reset after two outputs, then a fresh merge from out_cnt=0.
    drive(1'b1, 32'd70, 1'b0, 1'b1, 32'd71, 1'b0);
    drive(1'b1, 32'd72, 1'b0, 1'b1, 32'd73, 1'b0);
    drive(1'b1, 32'd74, 1'b0, 1'b1, 32'd75, 1'b0);
    wait_out(2);
    RST = 1'b1;
    tick();
    chk_reset("s6 reset");
    RST = 1'b0;
    got_q.delete();
    drive(1'b1, 32'd80, 1'b1, 1'b1, 32'd81, 1'b1);
    wait_out(2);
    tick();
    chk("s6 out_cnt", BW'(bus.out_cnt), BW'(32'd2));
    exp_q = '{ent(1'b1, 1'b0, 32'd80), ent(1'b0, 1'b1, 32'd81)};
    chk_stream("s6 fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
